// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode, execute,
// memory and write-back one step per clock and drives the datapath mux/strobe controls.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t state_r;
  state_t next_state_s;

  assign state = state_r;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; all controls held low while reset is asserted.
  always_comb begin
    next_state_s = state_r;
    pc_write     = 1'b0;
    branch       = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    pc_src       = 2'b00;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    if (rst) begin
      case (state_r)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            next_state_s = S_DECODE;
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_DECODE: begin
          // Branch target is precomputed here whatever the opcode turns out to be.
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: next_state_s = S_MEMADR;
            OP_RTYPE:     next_state_s = S_EXEC;
            OP_BEQ:       next_state_s = S_BRANCH;
            OP_ADDI:      next_state_s = S_ADDIEX;
            OP_J:         next_state_s = S_JUMP;
            default: begin
              illegal_op   = 1'b1;
              next_state_s = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode == OP_LW) begin
            next_state_s = S_MEMRD;
          end else if (opcode == OP_SW) begin
            next_state_s = S_MEMWR;
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_MEMRD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
          if (mem_ready) begin
            next_state_s = S_MEMWB;
          end else begin
            next_state_s = S_MEMRD;
          end
        end
        S_MEMWB: begin
          mem_to_reg   = 1'b1;
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        S_MEMWR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done   = 1'b1;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_MEMWR;
          end
        end
        S_EXEC: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b10;
          next_state_s = S_ALUWB;
        end
        S_ALUWB: begin
          reg_dst      = 1'b1;
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b01;
          pc_src       = 2'b01;
          branch       = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          next_state_s = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write    = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        S_JUMP: begin
          pc_src       = 2'b10;
          pc_write     = 1'b1;
          instr_done   = 1'b1;
          next_state_s = S_FETCH;
        end
        default: next_state_s = S_FETCH;
      endcase
    end else begin
      next_state_s = S_FETCH;
    end
  end

endmodule
